// File: rtl/graph_loader_if.sv
// graph_loader bus: edge input stream plus graph hand-off to the engine.
// slave = loader side, master = edge source / engine side.
interface graph_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_edge;
   logic        in_last;
   logic [3:0]  n;
   logic [7:0]  e;
   logic [11:0] data [0:255];
   logic        dj_valid;
   logic        dj_ready;
   logic        dj_done;

   modport slave (
      input  in_valid, in_edge, in_last, dj_ready, dj_done,
      output in_ready, n, e, data, dj_valid
   );

   modport master (
      output in_valid, in_edge, in_last, dj_ready, dj_done,
      input  in_ready, n, e, data, dj_valid
   );
endinterface

// File: rtl/graph_loader.sv
// graph_loader: validates an edge stream, packs it into a 256-entry
// buffer and hands the finished graph to the shortest-path engine.
module graph_loader #(
   parameter int MAX_E = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] cfg_n,
   output logic       busy,
   output logic       err,
   graph_loader_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      PRESENT = 2'd2,
      RUN     = 2'd3
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(MAX_E - 1);

   state_t     state;
   logic [3:0] n_q;
   logic [7:0] e_q;
   logic       err_q;

   logic       accept;
   logic       edge_ok;
   logic       hit_max;

   // handshake outputs come straight from the state register
   assign bus.in_ready = (state == LOAD);
   assign bus.dj_valid = (state == PRESENT);
   assign busy         = (state != IDLE);
   assign err          = err_q;
   assign bus.n        = n_q;
   assign bus.e        = e_q;

   // edge acceptance and index validation
   always_comb begin
      accept  = (state == LOAD) && bus.in_valid;
      edge_ok = (bus.in_edge[3:0] < n_q) && (bus.in_edge[7:4] < n_q);
      hit_max = edge_ok && (e_q == LAST_IDX);
   end

   // control FSM with node count, edge count and sticky error
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         n_q   <= 4'd0;
         e_q   <= 8'd0;
         err_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_n != 4'd0) begin
                     n_q   <= cfg_n;
                     e_q   <= 8'd0;
                     err_q <= 1'b0;
                     state <= LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  if (edge_ok) begin
                     e_q <= e_q + 8'd1;
                  end else begin
                     err_q <= 1'b1;
                  end
                  if (bus.in_last) begin
                     state <= PRESENT;
                  end else if (hit_max) begin
                     err_q <= 1'b1;
                     state <= PRESENT;
                  end
               end
            end
            PRESENT: begin
               if (bus.dj_ready) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (bus.dj_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // edge buffer; never reset, entries past e are don't-care
   always_ff @(posedge clk) begin
      if (accept && edge_ok) begin
         bus.data[e_q] <= bus.in_edge;
      end
   end

endmodule

// File: tb/tb_graph_loader.sv
// Scoreboard bench for graph_loader: expected graphs are queued by
// the driver and checked by a monitor when dj_valid rises.
module tb_graph_loader;

   typedef struct {
      logic [3:0]  n;
      logic [7:0]  e;
      logic        err;
      int          nchk;
      logic [11:0] d0;
      logic [11:0] d1;
      logic [11:0] d2;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] cfg_n;
   logic       busy;
   logic       err;

   int passed;
   int total;

   exp_t sb[$];

   graph_loader_if bus ();

   graph_loader #(.MAX_E(255)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .cfg_n (cfg_n),
      .busy  (busy),
      .err   (err),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endfunction

   function automatic exp_t mk(logic [3:0] n, logic [7:0] e, logic er,
                               int nc, logic [11:0] a, logic [11:0] b,
                               logic [11:0] c);
      exp_t x;
      x.n = n; x.e = e; x.err = er; x.nchk = nc;
      x.d0 = a; x.d1 = b; x.d2 = c;
      return x;
   endfunction

   // monitor: compare on each rising dj_valid
   logic prev_v;
   initial prev_v = 1'b0;
   always @(negedge clk) begin
      if (bus.dj_valid && !prev_v) begin
         if (sb.size() == 0) begin
            chk("unexpected_dj_valid", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("graph_n", 32'(bus.n), 32'(x.n));
            chk("graph_e", 32'(bus.e), 32'(x.e));
            chk("graph_err", 32'(err), 32'(x.err));
            if (x.nchk > 0) chk("data0", 32'(bus.data[0]), 32'(x.d0));
            if (x.nchk > 1) chk("data1", 32'(bus.data[1]), 32'(x.d1));
            if (x.nchk > 2) chk("data2", 32'(bus.data[2]), 32'(x.d2));
         end
      end
      prev_v = bus.dj_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(logic [3:0] nn);
      start = 1'b1;
      cfg_n = nn;
      tick();
      start = 1'b0;
   endtask

   task automatic send(logic [11:0] w, logic last);
      int k;
      bus.in_valid = 1'b1;
      bus.in_edge  = w;
      bus.in_last  = last;
      k = 0;
      while (!bus.in_ready && k < 10) begin
         tick();
         k++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic finish_graph();
      int k;
      k = 0;
      while (!bus.dj_valid && k < 20) begin
         tick();
         k++;
      end
      if (!bus.dj_valid) chk("dj_valid_timeout", 32'd0, 32'd1);
      bus.dj_ready = 1'b1;
      tick();
      bus.dj_ready = 1'b0;
      bus.dj_done  = 1'b1;
      tick();
      bus.dj_done  = 1'b0;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset = 1'b0;
      start = 1'b0;
      cfg_n = 4'd0;
      bus.in_valid = 1'b0;
      bus.in_edge  = 12'd0;
      bus.in_last  = 1'b0;
      bus.dj_ready = 1'b0;
      bus.dj_done  = 1'b0;
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_dj_valid", 32'(bus.dj_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_n", 32'(bus.n), 32'd0);
      chk("rst_e", 32'(bus.e), 32'd0);
      reset = 1'b1;
      tick();

      // basic load and handshake
      sb.push_back(mk(4'd4, 8'd3, 1'b0, 3, 12'h301, 12'h512, 12'h123));
      do_start(4'd4);
      chk("busy_after_start", 32'(busy), 32'd1);
      send(12'h301, 1'b0);
      send(12'h512, 1'b0);
      send(12'h123, 1'b1);
      chk("dj_valid_after_last", 32'(bus.dj_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_dj_valid", 32'(bus.dj_valid), 32'd1);
         chk("hold_data2", 32'(bus.data[2]), 32'h123);
         chk("hold_e", 32'(bus.e), 32'd3);
      end
      bus.dj_ready = 1'b1;
      tick();
      bus.dj_ready = 1'b0;
      chk("dj_valid_drop", 32'(bus.dj_valid), 32'd0);
      chk("busy_in_run", 32'(busy), 32'd1);
      tick();
      chk("run_holds", 32'(busy), 32'd1);
      bus.dj_done = 1'b1;
      tick();
      bus.dj_done = 1'b0;
      chk("busy_after_done", 32'(busy), 32'd0);

      // bad edge
      sb.push_back(mk(4'd3, 8'd2, 1'b1, 2, 12'h201, 12'h112, 12'h000));
      do_start(4'd3);
      send(12'h201, 1'b0);
      send(12'h431, 1'b0);
      chk("err_after_bad", 32'(err), 32'd1);
      chk("e_after_bad", 32'(bus.e), 32'd1);
      send(12'h112, 1'b1);
      finish_graph();

      // full buffer
      sb.push_back(mk(4'd2, 8'd255, 1'b1, 3, 12'h110, 12'h110, 12'h110));
      do_start(4'd2);
      chk("err_cleared", 32'(err), 32'd0);
      for (int i = 0; i < 255; i++) send(12'h110, 1'b0);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_dj_valid", 32'(bus.dj_valid), 32'd1);
      chk("full_data254", 32'(bus.data[254]), 32'h110);
      bus.in_valid = 1'b1;
      bus.in_edge  = 12'h001;
      tick();
      bus.in_valid = 1'b0;
      chk("full_e_held", 32'(bus.e), 32'd255);
      finish_graph();

      // start ignored during load
      sb.push_back(mk(4'd4, 8'd2, 1'b0, 2, 12'h010, 12'h021, 12'h000));
      do_start(4'd4);
      send(12'h010, 1'b0);
      do_start(4'd9);
      chk("ign_start_n", 32'(bus.n), 32'd4);
      chk("ign_start_e", 32'(bus.e), 32'd1);
      send(12'h021, 1'b1);
      finish_graph();

      // cfg_n zero
      do_start(4'd0);
      chk("n0_err", 32'(err), 32'd1);
      chk("n0_busy", 32'(busy), 32'd0);

      // last on first edge
      sb.push_back(mk(4'd5, 8'd1, 1'b0, 1, 12'h043, 12'h000, 12'h000));
      do_start(4'd5);
      send(12'h043, 1'b1);
      finish_graph();

      // reset mid-load
      do_start(4'd8);
      for (int i = 0; i < 7; i++) send(12'h210, 1'b0);
      chk("mid_e7", 32'(bus.e), 32'd7);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mid_rst_e", 32'(bus.e), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      repeat (10) tick();
      chk("mid_rst_no_valid", 32'(bus.dj_valid), 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
